// File: rtl/tile_pkg.sv
// Shared types, field layout and default geometry for the layered tile blitter.
package tile_pkg;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DRAIN, DONE} blit_state_t;

   localparam int unsigned LAYER_FIELD_W   = 11;
   localparam int unsigned LAYER_FIELD_LSB = 10;

   localparam int unsigned DEF_TILE_SIZE = 24;
   localparam int unsigned DEF_MAP_COLS  = 26;
   localparam int unsigned DEF_MAP_ROWS  = 20;
   localparam int unsigned DEF_FB_WIDTH  = 640;

   // Sprite index of layer k inside a 32-bit tile map entry.
   function automatic logic [LAYER_FIELD_W-1:0] layer_idx(input logic [31:0] entry,
                                                          input int unsigned k);
      return entry[LAYER_FIELD_LSB + LAYER_FIELD_W*k +: LAYER_FIELD_W];
   endfunction

endpackage

// File: rtl/layer_compositor.sv
// Tagged accumulator: folds the per-layer ROM colours of one pixel and emits
// the frame-buffer write once the last layer of that pixel has arrived.
module layer_compositor #(
   parameter logic [3:0] BG_IDX          = 4'h0,
   parameter logic [3:0] TRANSPARENT_IDX = 4'h0
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  rom_data_i,
   input  logic        tag_vld_i,
   input  logic        tag_layer_i,
   input  logic        tag_last_i,
   input  logic        tag_empty_i,
   input  logic [18:0] tag_addr_i,
   output logic        fb_we_o,
   output logic [18:0] fb_addr_o,
   output logic [3:0]  fb_data_o
);

   logic [3:0]  acc_q, acc_d;
   logic        fb_we_q;
   logic [18:0] fb_addr_q;
   logic [3:0]  fb_data_q;

   // Layer 0 restarts from the background; higher opaque layers overwrite.
   always_comb begin
      acc_d = tag_layer_i ? acc_q : BG_IDX;
      if (!tag_empty_i && (rom_data_i != TRANSPARENT_IDX))
         acc_d = rom_data_i;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q     <= '0;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
      end else begin
         fb_we_q <= tag_vld_i & tag_last_i;
         if (tag_vld_i) begin
            acc_q <= acc_d;
            if (tag_last_i) begin
               fb_data_q <= acc_d;
               fb_addr_q <= tag_addr_i;
            end
         end
      end
   end

   assign fb_we_o   = fb_we_q;
   assign fb_addr_o = fb_addr_q;
   assign fb_data_o = fb_data_q;

endmodule

// File: rtl/tile_layer_blitter.sv
// Walks the tile map, issues one sprite ROM read per layer per pixel and feeds
// the compositor, which writes the frame-buffer page selected by fb_page.
module tile_layer_blitter
   import tile_pkg::*;
#(
   parameter int unsigned TILE_SIZE       = DEF_TILE_SIZE,
   parameter int unsigned MAP_COLS        = DEF_MAP_COLS,
   parameter int unsigned MAP_ROWS        = DEF_MAP_ROWS,
   parameter int unsigned NUM_LAYERS      = 2,
   parameter int unsigned FB_WIDTH        = DEF_FB_WIDTH,
   parameter int unsigned ROM_ADDR_W      = 16,
   parameter logic [3:0]  BG_IDX          = 4'h0,
   parameter logic [3:0]  TRANSPARENT_IDX = 4'h0
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fb_page,
   output logic [9:0]            state_ram_addr,
   input  logic [31:0]           state_ram_data,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [3:0]            rom_data,
   output logic                  fb_we,
   output logic [18:0]           fb_addr,
   output logic [3:0]            fb_data
);

   localparam int unsigned TILE_AREA = TILE_SIZE * TILE_SIZE;
   localparam int unsigned PW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
   localparam int unsigned XW = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
   localparam int unsigned YW = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;

   blit_state_t state_q, state_d;
   logic [XW-1:0] tx_q, tx_d;
   logic [YW-1:0] ty_q, ty_d;
   logic [PW-1:0] px_q, px_d;
   logic [PW-1:0] py_q, py_d;
   logic          layer_q, layer_d;
   logic          drain_q, drain_d;
   logic [31:0]   entry_q, entry_d;
   logic          page_q, page_d;

   logic          vld_p1_q, layer_p1_q, last_p1_q, empty_p1_q;
   logic [18:0]   addr_p1_q;

   logic [LAYER_FIELD_W-1:0] idx_cur;
   logic [18:0]   pix_addr;
   logic          layer_last, px_last, py_last, tx_last, ty_last;

   always_comb begin
      idx_cur  = layer_idx(entry_q, 32'(layer_q));
      pix_addr = 19'((32'(ty_q) * TILE_SIZE + 32'(py_q)) * FB_WIDTH
                     + 32'(tx_q) * TILE_SIZE + 32'(px_q));
   end

   assign rom_addr       = ROM_ADDR_W'(32'(idx_cur) * TILE_AREA
                                       + 32'(py_q) * TILE_SIZE + 32'(px_q));
   assign state_ram_addr = 10'(32'(ty_q) * MAP_COLS + 32'(tx_q));

   assign layer_last = (layer_q == 1'(NUM_LAYERS - 1));
   assign px_last    = (px_q == PW'(TILE_SIZE - 1));
   assign py_last    = (py_q == PW'(TILE_SIZE - 1));
   assign tx_last    = (tx_q == XW'(MAP_COLS - 1));
   assign ty_last    = (ty_q == YW'(MAP_ROWS - 1));

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign fb_page = page_q;

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      ty_d    = ty_q;
      px_d    = px_q;
      py_d    = py_q;
      layer_d = layer_q;
      drain_d = drain_q;
      entry_d = entry_q;
      page_d  = page_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               tx_d    = '0;
               ty_d    = '0;
               px_d    = '0;
               py_d    = '0;
               layer_d = 1'b0;
            end
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            entry_d = state_ram_data;
            state_d = DRAW;
         end
         DRAW: begin
            // Layer is the fastest counter, then px, then py, then the tile.
            if (!layer_last) begin
               layer_d = layer_q + 1'b1;
            end else begin
               layer_d = 1'b0;
               if (!px_last) begin
                  px_d = px_q + 1'b1;
               end else begin
                  px_d = '0;
                  if (!py_last) begin
                     py_d = py_q + 1'b1;
                  end else begin
                     py_d    = '0;
                     state_d = FETCH;
                     if (!tx_last) begin
                        tx_d = tx_q + 1'b1;
                     end else begin
                        tx_d = '0;
                        if (ty_last) begin
                           state_d = DRAIN;
                           drain_d = 1'b0;
                        end else begin
                           ty_d = ty_q + 1'b1;
                        end
                     end
                  end
               end
            end
         end
         DRAIN: begin
            if (drain_q) state_d = DONE;
            else         drain_d = 1'b1;
         end
         DONE: begin
            page_d  = ~page_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_q       <= '0;
         ty_q       <= '0;
         px_q       <= '0;
         py_q       <= '0;
         layer_q    <= 1'b0;
         drain_q    <= 1'b0;
         entry_q    <= '0;
         page_q     <= 1'b0;
         vld_p1_q   <= 1'b0;
         layer_p1_q <= 1'b0;
         last_p1_q  <= 1'b0;
         empty_p1_q <= 1'b0;
         addr_p1_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         ty_q       <= ty_d;
         px_q       <= px_d;
         py_q       <= py_d;
         layer_q    <= layer_d;
         drain_q    <= drain_d;
         entry_q    <= entry_d;
         page_q     <= page_d;
         // Issue tags, aligned with the ROM data returning next cycle.
         vld_p1_q   <= (state_q == DRAW);
         layer_p1_q <= layer_q;
         last_p1_q  <= layer_last;
         empty_p1_q <= (idx_cur == '0);
         addr_p1_q  <= pix_addr;
      end
   end

   layer_compositor #(
      .BG_IDX          (BG_IDX),
      .TRANSPARENT_IDX (TRANSPARENT_IDX)
   ) u_comp (
      .clock       (clock),
      .reset       (reset),
      .rom_data_i  (rom_data),
      .tag_vld_i   (vld_p1_q),
      .tag_layer_i (layer_p1_q),
      .tag_last_i  (last_p1_q),
      .tag_empty_i (empty_p1_q),
      .tag_addr_i  (addr_p1_q),
      .fb_we_o     (fb_we),
      .fb_addr_o   (fb_addr),
      .fb_data_o   (fb_data)
   );

endmodule

// File: tb/tb_tile_layer_blitter.sv
// Directed bench for tile_layer_blitter on a 2x1 map of 2x2 tiles, two layers.
module tb_tile_layer_blitter;

   logic        clock;
   logic        reset;
   logic        start;
   logic        busy, done, fb_page, fb_we;
   logic [9:0]  state_ram_addr;
   logic [31:0] state_ram_data;
   logic [15:0] rom_addr;
   logic [3:0]  rom_data;
   logic [18:0] fb_addr;
   logic [3:0]  fb_data;

   logic [31:0] sram [0:3];
   int          rom_mode;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          wr_addr [256];
   int          wr_data [256];
   int          wr_cyc  [256];
   logic        busy_tr [64];
   logic [15:0] rom_tr  [64];
   logic [9:0]  sram_tr [64];
   int          exp_addr [8] = '{0, 1, 4, 5, 2, 3, 6, 7};

   tile_layer_blitter #(
      .TILE_SIZE       (2),
      .MAP_COLS        (2),
      .MAP_ROWS        (1),
      .NUM_LAYERS      (2),
      .FB_WIDTH        (4),
      .ROM_ADDR_W      (16),
      .BG_IDX          (4'h3),
      .TRANSPARENT_IDX (4'h0)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .fb_page        (fb_page),
      .state_ram_addr (state_ram_addr),
      .state_ram_data (state_ram_data),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .fb_we          (fb_we),
      .fb_addr        (fb_addr),
      .fb_data        (fb_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Memory models with one-cycle read latency.
   always @(posedge clock) begin
      state_ram_data <= sram[state_ram_addr[1:0]];
      case (rom_mode)
         1:       rom_data <= rom_addr[3:0] | 4'h1;
         2:       rom_data <= (rom_addr >= 16'd4 && rom_addr < 16'd8) ? 4'h5 : 4'h0;
         default: rom_data <= 4'hF;
      endcase
   end

   always @(negedge clock) begin
      if (fb_we === 1'b1) begin
         wr_addr[wr_cnt % 256] = int'(fb_addr);
         wr_data[wr_cnt % 256] = int'(fb_data);
         wr_cyc[wr_cnt % 256]  = cyc;
         wr_cnt++;
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      busy_tr[cyc % 64] = busy;
      rom_tr[cyc % 64]  = rom_addr;
      sram_tr[cyc % 64] = state_ram_addr;
   end

   task automatic run_frame(input bit hold, output int t0, output bit ok);
      ok = 1'b0;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      t0 = cyc;
      if (!hold) start = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({busy, done, fb_page, fb_we} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl got busy/done/page/we=%b want 0000", {busy, done, fb_page, fb_we});
      end
      checks++;
      if (fb_addr !== 19'd0 || fb_data !== 4'd0) begin
         errors++;
         $display("FAIL reset_fb got addr=%0d data=%0d want 0 0", fb_addr, fb_data);
      end
      checks++;
      if (rom_addr !== 16'd0 || state_ram_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset_addr got rom=%0d sram=%0d want 0 0", rom_addr, state_ram_addr);
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || fb_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b we=%b want 0 0", busy, fb_we);
      end
   endtask

   task automatic test_opaque_layers();
      int t0; bit ok; int base; int dbase;
      int exp_d [8];
      exp_d = '{9, 9, 11, 11, 3, 3, 3, 3};
      sram[0] = (32'd2 << 21) | (32'd1 << 10);
      sram[1] = 32'd0;
      rom_mode = 1;
      base = wr_cnt;
      dbase = done_cnt;
      run_frame(1'b0, t0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL opaque_timeout got no done want done"); end
      checks++;
      if (wr_cnt - base != 8) begin
         errors++; $display("FAIL opaque_count got %0d want 8", wr_cnt - base);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_addr[(base + i) % 256] !== exp_addr[i] || wr_data[(base + i) % 256] !== exp_d[i]) begin
            errors++;
            $display("FAIL opaque_wr%0d got addr=%0d data=%0d want addr=%0d data=%0d", i,
                     wr_addr[(base + i) % 256], wr_data[(base + i) % 256], exp_addr[i], exp_d[i]);
         end
      end
      checks++;
      if (wr_cyc[base % 256] - t0 != 5) begin
         errors++; $display("FAIL opaque_first_we got cycle %0d want 5", wr_cyc[base % 256] - t0);
      end
      checks++;
      if (wr_cyc[(base + 7) % 256] - t0 != 21) begin
         errors++; $display("FAIL opaque_last_we got cycle %0d want 21", wr_cyc[(base + 7) % 256] - t0);
      end
      checks++;
      if (done_cyc - t0 != 22 || done_cnt - dbase != 1) begin
         errors++;
         $display("FAIL opaque_done got cycle %0d pulses %0d want 22 1", done_cyc - t0, done_cnt - dbase);
      end
      checks++;
      if (fb_page !== 1'b1) begin errors++; $display("FAIL opaque_page got %b want 1", fb_page); end
      checks++;
      if (busy_tr[t0 % 64] !== 1'b1 || busy_tr[(t0 + 23) % 64] !== 1'b0) begin
         errors++;
         $display("FAIL opaque_busy got first=%b after=%b want 1 0", busy_tr[t0 % 64], busy_tr[(t0 + 23) % 64]);
      end
      checks++;
      if (rom_tr[(t0 + 2) % 64] !== 16'd4) begin
         errors++; $display("FAIL opaque_rom0 got %0d want 4", rom_tr[(t0 + 2) % 64]);
      end
   endtask

   task automatic test_transparency();
      int t0; bit ok; int base;
      int exp_d [8];
      exp_d = '{5, 5, 5, 5, 3, 3, 3, 3};
      sram[0] = (32'd2 << 21) | (32'd1 << 10);
      sram[1] = (32'd2 << 21) | (32'd3 << 10);
      rom_mode = 2;
      base = wr_cnt;
      run_frame(1'b0, t0, ok);
      checks++;
      if (!ok || wr_cnt - base != 8) begin
         errors++; $display("FAIL transp_count got ok=%b writes=%0d want 1 8", ok, wr_cnt - base);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_addr[(base + i) % 256] !== exp_addr[i] || wr_data[(base + i) % 256] !== exp_d[i]) begin
            errors++;
            $display("FAIL transp_wr%0d got addr=%0d data=%0d want addr=%0d data=%0d", i,
                     wr_addr[(base + i) % 256], wr_data[(base + i) % 256], exp_addr[i], exp_d[i]);
         end
      end
      checks++;
      if (fb_page !== 1'b0) begin errors++; $display("FAIL transp_page got %b want 0", fb_page); end
   endtask

   task automatic test_empty_entry();
      int t0; bit ok; int base;
      sram[0] = 32'd0;
      sram[1] = 32'd0;
      rom_mode = 3;
      base = wr_cnt;
      run_frame(1'b0, t0, ok);
      checks++;
      if (!ok || wr_cnt - base != 8) begin
         errors++; $display("FAIL empty_count got ok=%b writes=%0d want 1 8", ok, wr_cnt - base);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_addr[(base + i) % 256] !== exp_addr[i] || wr_data[(base + i) % 256] !== 3) begin
            errors++;
            $display("FAIL empty_wr%0d got addr=%0d data=%0d want addr=%0d data=3", i,
                     wr_addr[(base + i) % 256], wr_data[(base + i) % 256], exp_addr[i]);
         end
      end
      checks++;
      if (fb_page !== 1'b1) begin errors++; $display("FAIL empty_page got %b want 1", fb_page); end
   endtask

   task automatic test_addressing();
      int t0; bit ok; int base;
      sram[0] = (32'd2 << 21) | (32'd1 << 10);
      sram[1] = (32'd2 << 21) | (32'd2 << 10);
      rom_mode = 1;
      base = wr_cnt;
      run_frame(1'b0, t0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL addr_timeout got no done want done"); end
      checks++;
      if (wr_addr[(base + 7) % 256] !== 7 || wr_data[(base + 7) % 256] !== 11) begin
         errors++;
         $display("FAIL addr_tile1_px11 got addr=%0d data=%0d want 7 11",
                  wr_addr[(base + 7) % 256], wr_data[(base + 7) % 256]);
      end
      checks++;
      if (rom_tr[(t0 + 7) % 64] !== 16'd10) begin
         errors++; $display("FAIL addr_rom_py1 got %0d want 10", rom_tr[(t0 + 7) % 64]);
      end
      checks++;
      if (rom_tr[(t0 + 19) % 64] !== 16'd11) begin
         errors++; $display("FAIL addr_rom_tile1 got %0d want 11", rom_tr[(t0 + 19) % 64]);
      end
      checks++;
      if (sram_tr[t0 % 64] !== 10'd0 || sram_tr[(t0 + 10) % 64] !== 10'd1) begin
         errors++;
         $display("FAIL addr_sram got %0d,%0d want 0,1", sram_tr[t0 % 64], sram_tr[(t0 + 10) % 64]);
      end
      checks++;
      if (fb_page !== 1'b0) begin errors++; $display("FAIL addr_page got %b want 0", fb_page); end
   endtask

   task automatic test_start_held();
      int t0; bit ok; int base; int dbase;
      sram[0] = (32'd2 << 21) | (32'd1 << 10);
      sram[1] = 32'd0;
      rom_mode = 1;
      base = wr_cnt;
      dbase = done_cnt;
      run_frame(1'b1, t0, ok);
      checks++;
      if (!ok || wr_cnt - base != 8 || done_cnt - dbase != 1) begin
         errors++;
         $display("FAIL held_frame got ok=%b writes=%0d dones=%0d want 1 8 1", ok, wr_cnt - base, done_cnt - dbase);
      end
      checks++;
      if (done_cyc - t0 != 22) begin
         errors++; $display("FAIL held_done got cycle %0d want 22", done_cyc - t0);
      end
      checks++;
      if (fb_page !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL held_page got page=%b busy=%b want 1 0", fb_page, busy);
      end
      base = wr_cnt;
      run_frame(1'b0, t0, ok);
      checks++;
      if (!ok || wr_cnt - base != 8) begin
         errors++; $display("FAIL second_frame got ok=%b writes=%0d want 1 8", ok, wr_cnt - base);
      end
      checks++;
      if (fb_page !== 1'b0) begin errors++; $display("FAIL second_page got %b want 0", fb_page); end
   endtask

   task automatic test_async_reset();
      int t0; bit ok; int base;
      int exp_d [8];
      exp_d = '{9, 9, 11, 11, 3, 3, 3, 3};
      sram[0] = (32'd2 << 21) | (32'd1 << 10);
      sram[1] = 32'd0;
      rom_mode = 1;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, fb_page, fb_we} !== 4'b0000 || fb_addr !== 19'd0 || fb_data !== 4'd0
          || rom_addr !== 16'd0 || state_ram_addr !== 10'd0) begin
         errors++;
         $display("FAIL areset_outputs got ctrl=%b fb=%0d/%0d rom=%0d sram=%0d want all 0",
                  {busy, done, fb_page, fb_we}, fb_addr, fb_data, rom_addr, state_ram_addr);
      end
      base = wr_cnt;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (30) @(negedge clock);
      checks++;
      if (wr_cnt != base || busy !== 1'b0) begin
         errors++; $display("FAIL areset_quiet got writes=%0d busy=%b want 0 0", wr_cnt - base, busy);
      end
      base = wr_cnt;
      run_frame(1'b0, t0, ok);
      checks++;
      if (!ok || wr_cnt - base != 8 || done_cyc - t0 != 22) begin
         errors++;
         $display("FAIL areset_frame got ok=%b writes=%0d done=%0d want 1 8 22", ok, wr_cnt - base, done_cyc - t0);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_addr[(base + i) % 256] !== exp_addr[i] || wr_data[(base + i) % 256] !== exp_d[i]) begin
            errors++;
            $display("FAIL areset_wr%0d got addr=%0d data=%0d want addr=%0d data=%0d", i,
                     wr_addr[(base + i) % 256], wr_data[(base + i) % 256], exp_addr[i], exp_d[i]);
         end
      end
      checks++;
      if (fb_page !== 1'b1) begin errors++; $display("FAIL areset_page got %b want 1", fb_page); end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      rom_mode = 0;
      for (int i = 0; i < 4; i++) sram[i] = 32'd0;
      test_reset();
      test_opaque_layers();
      test_transparency();
      test_empty_entry();
      test_addressing();
      test_start_held();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
